// File: rtl/jam_pkg.sv
// Shared definitions for the JAM core and its cost server: matrix size,
// cost width, result widths and the server state encoding.
package jam_pkg;

  localparam int JAM_N      = 8;
  localparam int JAM_COST_W = 7;
  localparam int JAM_IDX_W  = $clog2(JAM_N);
  localparam int JAM_MC_W   = 4;
  localparam int JAM_MIN_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/jam_cost_server_if.sv
// Load port and JAM query/result signals between the JAM core (master)
// and the cost server (slave).
interface jam_cost_server_if #(
  parameter int N      = jam_pkg::JAM_N,
  parameter int COST_W = jam_pkg::JAM_COST_W
);
  import jam_pkg::*;

  localparam int IDX_W = $clog2(N);

  logic                 ld_valid;
  logic [COST_W-1:0]    ld_data;
  logic                 ld_ready;
  logic [IDX_W-1:0]     W;
  logic [IDX_W-1:0]     J;
  logic [COST_W-1:0]    Cost;
  logic [JAM_MC_W-1:0]  MatchCount;
  logic [JAM_MIN_W-1:0] MinCost;
  logic                 Valid;

  modport master (
    output ld_valid, ld_data, W, J, MatchCount, MinCost, Valid,
    input  ld_ready, Cost
  );

  modport slave (
    input  ld_valid, ld_data, W, J, MatchCount, MinCost, Valid,
    output ld_ready, Cost
  );

endinterface

// File: rtl/jam_cost_ram.sv
// Cost table storage: synchronous write, asynchronous read, no reset on the
// contents so the array maps onto plain registers or distributed RAM.
module jam_cost_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 7,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_sys,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_server.sv
// JAM cost server: serial table load, zero-latency Cost lookup, query count
// and result capture. Optional watchdog enabled by defining WATCHDOG_EN.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   LOAD  | accepting 64 row-major cost words, ld_ready high
//   SERVE | answering W/J with Cost, counting cycles, waiting for Valid
//   DONE  | result captured (or watchdog fired), held until next start
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int N       = JAM_N,
  parameter int COST_W  = JAM_COST_W,
  parameter int QCNT_W  = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  jam_cost_server_if.slave     bus,
  output logic                 serving,
  output logic                 done,
  output logic [JAM_MC_W-1:0]  res_count,
  output logic [JAM_MIN_W-1:0] res_min,
  output logic [QCNT_W-1:0]    query_cnt,
  output logic                 timeout
);

  localparam int IDX_W = $clog2(N);
  localparam int AW    = 2 * IDX_W;
  localparam int DEPTH = N * N;

  state_t            state, state_nx;
  logic [AW-1:0]     addr;
  logic              ld_fire;
  logic              capture;
  logic [COST_W-1:0] rd_cost;

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;
`endif

  jam_cost_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (COST_W),
    .AW     (AW)
  ) u_ram (
    .clk_sys (CLK),
    .we      (ld_fire),
    .waddr   (addr),
    .wdata   (bus.ld_data),
    .raddr   ({bus.W, bus.J}),
    .rdata   (rd_cost)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // start overrides everything, including a Valid in the same cycle
  always_comb begin
    state_nx = state;
    ld_fire  = 1'b0;
    capture  = 1'b0;
`ifdef WATCHDOG_EN
    wd_fire  = 1'b0;
`endif
    if (start) begin
      state_nx = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (bus.ld_valid) begin
            ld_fire = 1'b1;
            if (addr == AW'(DEPTH - 1)) begin
              state_nx = SERVE;
            end
          end
        end
        SERVE: begin
          if (bus.Valid) begin
            capture  = 1'b1;
            state_nx = DONE;
          end
`ifdef WATCHDOG_EN
          else if (wd_cnt == '0) begin
            wd_fire  = 1'b1;
            state_nx = DONE;
          end
`endif
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr      <= '0;
      query_cnt <= '0;
      res_count <= '0;
      res_min   <= '0;
    end else if (start) begin
      addr      <= '0;
      query_cnt <= '0;
      res_count <= '0;
      res_min   <= '0;
    end else begin
      if (ld_fire) begin
        addr <= addr + 1'b1;
      end
      if (state == SERVE && query_cnt != '1) begin
        query_cnt <= query_cnt + 1'b1;
      end
      if (capture) begin
        res_count <= bus.MatchCount;
        res_min   <= bus.MinCost;
      end
    end
  end

`ifdef WATCHDOG_EN
  // down-counter reaches zero in the TIMEOUT-th SERVE cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wd_cnt  <= WD_W'(TIMEOUT - 1);
      timeout <= 1'b0;
    end else if (start) begin
      wd_cnt  <= WD_W'(TIMEOUT - 1);
      timeout <= 1'b0;
    end else begin
      if (state == SERVE && wd_cnt != '0) begin
        wd_cnt <= wd_cnt - 1'b1;
      end
      if (wd_fire) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  // no watchdog in this build; timeout is constant 0
  assign timeout = 1'b0 && (TIMEOUT != 0);
`endif

  assign bus.ld_ready = (state == LOAD);
  assign bus.Cost     = (state == SERVE) ? rd_cost : '0;
  assign serving      = (state == SERVE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: directed sequences, a query vector
// table and randomized traffic checked against a cycle-level reference model.
module tb_jam_cost_server;

  localparam int TB_TIMEOUT = 100;
  localparam int MP_IDLE = 0, MP_LOAD = 1, MP_SERVE = 2, MP_DONE = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        serving, done, timeout;
  logic [3:0]  res_count;
  logic [9:0]  res_min;
  logic [15:0] query_cnt;

  jam_cost_server_if bus ();

  jam_cost_server #(
    .N(8), .COST_W(7), .QCNT_W(16), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .bus       (bus.slave),
    .serving   (serving),
    .done      (done),
    .res_count (res_count),
    .res_min   (res_min),
    .query_cnt (query_cnt),
    .timeout   (timeout)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase, words loaded, table, counters, results
  int m_phase = MP_IDLE;
  int m_cnt = 0, m_qc = 0, m_rc = 0, m_rm = 0, m_to = 0;
  int m_tbl [64];

  typedef struct {
    logic [2:0] w;
    logic [2:0] j;
    int         exp_cost;
  } qvec_t;
  qvec_t qv [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = MP_IDLE;
    m_cnt = 0; m_qc = 0; m_rc = 0; m_rm = 0; m_to = 0;
  endtask

  task automatic model_edge();
    if (start) begin
      m_phase = MP_LOAD;
      m_cnt = 0; m_qc = 0; m_rc = 0; m_rm = 0; m_to = 0;
    end else if (m_phase == MP_LOAD) begin
      if (bus.ld_valid) begin
        m_tbl[m_cnt] = int'(bus.ld_data);
        m_cnt++;
        if (m_cnt == 64) m_phase = MP_SERVE;
      end
    end else if (m_phase == MP_SERVE) begin
      if (m_qc < 65535) m_qc++;
      if (bus.Valid) begin
        m_rc = int'(bus.MatchCount);
        m_rm = int'(bus.MinCost);
        m_phase = MP_DONE;
      end
`ifdef WATCHDOG_EN
      else if (m_qc == TB_TIMEOUT) begin
        m_phase = MP_DONE;
        m_to = 1;
      end
`endif
    end
  endtask

  task automatic check_outputs();
    int exp_cost;
    exp_cost = (m_phase == MP_SERVE) ? m_tbl[int'(bus.W) * 8 + int'(bus.J)] : 0;
    chk("ld_ready", bus.ld_ready, (m_phase == MP_LOAD) ? 1 : 0);
    chk("serving", serving, (m_phase == MP_SERVE) ? 1 : 0);
    chk("done", done, (m_phase == MP_DONE) ? 1 : 0);
    chk("cost", bus.Cost, exp_cost);
    chk("res_count", res_count, m_rc);
    chk("res_min", res_min, m_rm);
    chk("query_cnt", query_cnt, m_qc);
    chk("timeout", timeout, m_to);
  endtask

  task automatic drive(input logic st, input logic lv, input logic [6:0] ld,
                       input logic [2:0] w, input logic [2:0] j, input logic v,
                       input logic [3:0] mc, input logic [9:0] mn);
    start = st; bus.ld_valid = lv; bus.ld_data = ld;
    bus.W = w; bus.J = j; bus.Valid = v; bus.MatchCount = mc; bus.MinCost = mn;
  endtask

  task automatic advance();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic cycle(input logic st, input logic lv, input logic [6:0] ld,
                       input logic [2:0] w, input logic [2:0] j, input logic v,
                       input logic [3:0] mc, input logic [9:0] mn);
    drive(st, lv, ld, w, j, v, mc, mn);
    #1;
    check_outputs();
    advance();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 7'd0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 4'd0, 10'd0);
  endtask

  task automatic pulse_start();
    cycle(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
  endtask

  function automatic logic [6:0] word_for(input int mode, input int i);
    if (mode == 0) return 7'(i % 100);
    if (mode == 1) return 7'(63 - i);
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic load_words(input int mode, input int beats);
    for (int i = 0; i < beats; i++) begin
      cycle(1'b0, 1'b1, word_for(mode, i), 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
    end
  endtask

  initial begin : watchdog_guard
    #1_000_000;
    n_bad++;
    $display("FAIL global_time_limit: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

  initial begin : main
    int acc;
    qv[0] = '{3'd3, 3'd5, 29};
    qv[1] = '{3'd7, 3'd7, 63};
    qv[2] = '{3'd0, 3'd0, 0};
    qv[3] = '{3'd0, 3'd7, 7};
    qv[4] = '{3'd7, 3'd0, 56};
    qv[5] = '{3'd1, 3'd2, 10};
    qv[6] = '{3'd6, 3'd3, 51};
    qv[7] = '{3'd5, 3'd5, 45};

    drive(1'b0, 1'b0, 7'd0, 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    check_outputs();
    RST = 1'b1;

    // gap-free load of table[i] = i % 100, then vector lookups
    pulse_start();
    load_words(0, 64);
    chk("ld_ready_after_64", bus.ld_ready, 0);
    chk("serving_after_64", serving, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 7'd0, qv[i].w, qv[i].j, 1'b0, 4'd0, 10'd0);
      #1;
      chk("vec_cost", bus.Cost, qv[i].exp_cost);
      check_outputs();
      advance();
    end
    repeat (31) idle_cycle();
    cycle(1'b0, 1'b0, 7'd0, 3'd2, 3'd2, 1'b1, 4'd2, 10'd321);
    chk("cap_done", done, 1);
    chk("cap_count", res_count, 2);
    chk("cap_min", res_min, 321);
    chk("cap_qcnt", query_cnt, 40);
    cycle(1'b0, 1'b0, 7'd0, 3'd0, 3'd0, 1'b1, 4'd5, 10'd77);
    chk("second_valid_count", res_count, 2);
    chk("second_valid_min", res_min, 321);
    chk("second_valid_qcnt", query_cnt, 40);

    // ld_valid toggling every other cycle
    pulse_start();
    acc = 0;
    for (int k = 0; k < 400 && acc < 64; k++) begin
      logic lv;
      lv = (k % 2) == 1;
      cycle(1'b0, lv, word_for(0, acc), 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
      if (lv) acc++;
      if (acc == 63) chk("gap_pre_serve", serving, 0);
    end
    chk("gap_beats", acc, 64);
    chk("gap_serving", serving, 1);
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b0, 7'd0, 3'(i / 8), 3'(i % 8), 1'b0, 4'd0, 10'd0);
      #1;
      chk("gap_table", bus.Cost, i);
      check_outputs();
      advance();
    end
    cycle(1'b0, 1'b0, 7'd0, 3'd0, 3'd0, 1'b1, 4'd1, 10'd500);

    // restart mid-load after 20 beats
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 7'(100 + i), 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
    end
    pulse_start();
    load_words(1, 63);
    chk("restart_not_serving", serving, 0);
    chk("restart_ld_ready", bus.ld_ready, 1);
    cycle(1'b0, 1'b1, 7'd0, 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
    chk("restart_serving", serving, 1);
    drive(1'b0, 1'b0, 7'd0, 3'd2, 3'd4, 1'b0, 4'd0, 10'd0);
    #1;
    chk("restart_cost_2_4", bus.Cost, 43);
    advance();

    // start and Valid together in SERVE: start wins
    cycle(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 1'b1, 4'd3, 10'd123);
    chk("start_wins_ld_ready", bus.ld_ready, 1);
    chk("start_wins_count", res_count, 0);
    chk("start_wins_min", res_min, 0);
    load_words(2, 64);
    repeat (5) idle_cycle();

    // async reset during SERVE
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_serving", serving, 0);
    chk("rst_qcnt", query_cnt, 0);
    chk("rst_cost", bus.Cost, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 7'd0, 3'd1, 3'd1, 1'b1, 4'd9, 10'd999);
    chk("rst_valid_ignored_done", done, 0);
    chk("rst_valid_ignored_min", res_min, 0);
    pulse_start();
    load_words(2, 64);
    chk("reload_serving", serving, 1);

`ifdef WATCHDOG_EN
    repeat (TB_TIMEOUT - 1) idle_cycle();
    chk("wd_pre_serving", serving, 1);
    chk("wd_pre_timeout", timeout, 0);
    idle_cycle();
    chk("wd_done", done, 1);
    chk("wd_timeout", timeout, 1);
    chk("wd_count", res_count, 0);
    chk("wd_min", res_min, 0);
    chk("wd_qcnt", query_cnt, TB_TIMEOUT);
`else
    repeat (200) idle_cycle();
    chk("nowd_serving", serving, 1);
    chk("nowd_timeout", timeout, 0);
    chk("nowd_qcnt", query_cnt, 200);
`endif

    // randomized traffic
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), $urandom_range(0, 59) == 0,
            4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
